// File: rtl/parking_gate_arbiter.sv
// Single-barrier parking gate shared by an entrance and an exit lane.
// Round-robin arbitration between lanes, bounded open window, occupancy tracking.
module parking_gate_arbiter #(
    parameter int CAPACITY    = 8,
    parameter int OPEN_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             timeout
);

    localparam int TMR_W = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OPEN_ENTRY = 2'd1,
        OPEN_EXIT  = 2'd2,
        CLOSE      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             ptr_q, ptr_d;   // 0: entry has priority, 1: exit has priority
    logic             entry_ok, exit_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            occ_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            occ_q   <= occ_d;
            ptr_q   <= ptr_d;
        end
    end

    assign entry_grant = (state_q == OPEN_ENTRY);
    assign exit_grant  = (state_q == OPEN_EXIT);
    assign gate_open   = entry_grant | exit_grant;
    assign occupancy   = occ_q;
    assign lot_full    = (occ_q == CAP);
    assign lot_empty   = (occ_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        occ_d    = occ_q;
        ptr_d    = ptr_q;
        timeout  = 1'b0;
        entry_ok = entry_req && !lot_full;
        exit_ok  = exit_req && !lot_empty;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (entry_ok && (!exit_ok || !ptr_q)) begin
                    state_d = OPEN_ENTRY;
                    ptr_d   = 1'b1;
                end else if (exit_ok) begin
                    state_d = OPEN_EXIT;
                    ptr_d   = 1'b0;
                end
            end
            OPEN_ENTRY, OPEN_EXIT: begin
                // A pass on the last window cycle wins over the timeout.
                if (car_passed) begin
                    state_d = CLOSE;
                    if (state_q == OPEN_ENTRY) begin
                        if (occ_q < CAP) occ_d = occ_q + 1'b1;
                    end else begin
                        if (occ_q != '0) occ_d = occ_q - 1'b1;
                    end
                end else if (timer_q == TMR_LAST) begin
                    timeout = reset;
                    state_d = CLOSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CLOSE: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with a lane/window model checked every cycle.
module tb_parking_gate_arbiter;

    localparam int CAP = 8;
    localparam int OC  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0, exit_req = 1'b0, car_passed = 1'b0;
    logic       entry_grant, exit_grant, gate_open, lot_full, lot_empty, timeout;
    logic [3:0] occupancy;

    int tests = 0;
    int fails = 0;

    parking_gate_arbiter #(.CAPACITY(CAP), .OPEN_CYCLES(OC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
        .car_passed(car_passed), .entry_grant(entry_grant), .exit_grant(exit_grant),
        .gate_open(gate_open), .occupancy(occupancy), .lot_full(lot_full),
        .lot_empty(lot_empty), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: where the gate is (0 idle, 1 entry window, 2 exit window, 3 closing),
    // how long the current window has been open, cars inside, whose turn on a tie.
    int m_where = 0;
    int m_age   = 0;
    int m_occ   = 0;
    bit m_exit_turn = 0;
    bit armed = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_where = 0; m_age = 0; m_occ = 0; m_exit_turn = 0; armed = 1;
        end else if (m_where == 0) begin
            bit e, x;
            e = entry_req && (m_occ < CAP);
            x = exit_req && (m_occ > 0);
            if (e && x) begin
                m_where = m_exit_turn ? 2 : 1;
            end else if (e) begin
                m_where = 1;
            end else if (x) begin
                m_where = 2;
            end
            if (m_where != 0) begin
                m_age = 0;
                m_exit_turn = (m_where == 1);
            end
        end else if (m_where == 3) begin
            m_where = 0;
        end else begin
            if (car_passed) begin
                if (m_where == 1 && m_occ < CAP) m_occ++;
                if (m_where == 2 && m_occ > 0) m_occ--;
                m_where = 3;
            end else if (m_age == OC - 1) begin
                m_where = 3;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            bit open;
            open = (m_where == 1) || (m_where == 2);
            check("entry_grant", entry_grant, m_where == 1);
            check("exit_grant",  exit_grant,  m_where == 2);
            check("gate_open",   gate_open,   open);
            check("occupancy",   occupancy,   m_occ);
            check("lot_full",    lot_full,    m_occ == CAP);
            check("lot_empty",   lot_empty,   m_occ == 0);
            check("timeout",     timeout,     open && reset && !car_passed && (m_age == OC - 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Request one lane, pass a car on the given open cycle (1-based), return to IDLE.
    task automatic pass_car(input bit exit_lane, input int open_cycle);
        if (exit_lane) exit_req = 1'b1; else entry_req = 1'b1;
        tick(1);
        entry_req = 1'b0; exit_req = 1'b0;
        tick(open_cycle - 1);
        car_passed = 1'b1;
        tick(1);
        car_passed = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    initial begin
        int gcount, tpos;
        bit granted;

        // Reset values
        tick(2);
        check("rst_gate_open", gate_open, 0);
        check("rst_lot_empty", lot_empty, 1);
        check("rst_timeout", timeout, 0);
        reset = 1'b1;

        // Basic entry, pass on 2nd open cycle
        entry_req = 1'b1;
        tick(1);
        entry_req = 1'b0;
        check("basic_open", gate_open, 1);
        check("basic_egrant", entry_grant, 1);
        tick(1);
        car_passed = 1'b1;
        tick(1);
        car_passed = 1'b0;
        check("basic_occ", occupancy, 1);
        check("basic_close", gate_open, 0);
        check("model_occ_basic", m_occ, 1);
        tick(1);

        // Fill to full
        for (int i = 0; i < 7; i++) pass_car(1'b0, 1);
        check("fill_occ", occupancy, 8);
        check("fill_full", lot_full, 1);
        entry_req = 1'b1;
        granted = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (entry_grant) granted = 1;
        end
        check("full_no_entry", granted, 0);
        exit_req = 1'b1;
        tick(1);
        entry_req = 1'b0; exit_req = 1'b0;
        check("full_exit_grant", exit_grant, 1);
        check("full_entry_grant", entry_grant, 0);
        car_passed = 1'b1;
        tick(1);
        car_passed = 1'b0;
        check("full_exit_occ", occupancy, 7);
        tick(1);

        // Simultaneous requests from occupancy 3 with entry's turn
        do_reset();
        for (int i = 0; i < 4; i++) pass_car(1'b0, 1);
        pass_car(1'b1, 1);
        check("sim_start_occ", occupancy, 3);
        entry_req = 1'b1; exit_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int waited;
            waited = 0;
            while (!gate_open && waited < 10) begin
                tick(1);
                waited++;
            end
            check("sim_wait", waited < 10, 1);
            check("sim_lane_entry", entry_grant, (i % 2) == 0);
            car_passed = 1'b1;
            tick(1);
            car_passed = 1'b0;
            check("sim_occ", occupancy, ((i % 2) == 0) ? 4 : 3);
        end
        entry_req = 1'b0; exit_req = 1'b0;
        tick(3);

        // Timeout: window of exactly OC cycles, timeout on the last one
        entry_req = 1'b1;
        tick(1);
        entry_req = 1'b0;
        gcount = 0; tpos = -1;
        for (int i = 0; i < 6; i++) begin
            if (gate_open) gcount++;
            if (timeout) tpos = gcount;
            tick(1);
        end
        check("to_open_cycles", gcount, 4);
        check("to_pulse_pos", tpos, 4);
        check("to_occ", occupancy, 3);
        // Pass on the final window cycle
        entry_req = 1'b1;
        tick(1);
        entry_req = 1'b0;
        tick(3);
        car_passed = 1'b1;
        #1;
        check("last_pass_gate", gate_open, 1);
        check("last_pass_no_to", timeout, 0);
        tick(1);
        car_passed = 1'b0;
        check("last_pass_occ", occupancy, 4);
        tick(1);

        // Empty lot: exit never granted
        do_reset();
        exit_req = 1'b1;
        granted = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (exit_grant) granted = 1;
        end
        exit_req = 1'b0;
        check("empty_no_exit", granted, 0);
        check("empty_flag", lot_empty, 1);

        // Reset mid-window with a concurrent pass
        pass_car(1'b0, 1);
        check("pre_rst_occ", occupancy, 1);
        entry_req = 1'b1;
        tick(1);
        entry_req = 1'b0;
        tick(1);
        reset = 1'b0; car_passed = 1'b1;
        tick(1);
        car_passed = 1'b0;
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_gate", gate_open, 0);
        check("mid_rst_egrant", entry_grant, 0);
        check("mid_rst_xgrant", exit_grant, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_empty", lot_empty, 1);
        check("mid_rst_full", lot_full, 0);
        reset = 1'b1;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
